// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for a single-port synchronous SRAM (1-cycle read latency).
// Optional sticky overflow/underflow flags are built when SRAM_FIFO_CTRL_ERR_EN is defined.
module sram_fifo_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [WIDTH-1:0]  push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_ready,
    output logic              pop_data_valid,
    output logic [WIDTH-1:0]  pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
`ifdef SRAM_FIFO_CTRL_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef struct packed {
        logic push;
        logic pop;
    } grant_t;

    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic              prio;
    logic              pushOk, popOk;
    grant_t            grant;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // One SRAM op per cycle; prio picks the winner only when both are eligible.
    always_comb begin
        pushOk     = push_valid && !full;
        popOk      = pop_req && !empty;
        grant      = '0;
        if (!rst) begin
            grant.push = pushOk && (!popOk || !prio);
            grant.pop  = popOk && !grant.push;
        end
    end

    assign push_ready = grant.push;
    assign pop_ready  = grant.pop;
    assign sram_write = grant.push;
    assign sram_read  = grant.pop;
    assign sram_addr  = grant.push ? wrPtr : rdPtr;
    assign sram_wdata = push_data;
    assign pop_data   = sram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            prio           <= 1'b0;
            pop_data_valid <= 1'b0;
        end else begin
            if (grant.push)
                wrPtr <= wrPtr + ADDR_W'(1);
            if (grant.pop)
                rdPtr <= rdPtr + ADDR_W'(1);
            if (grant.push)
                count <= count + (ADDR_W+1)'(1);
            else if (grant.pop)
                count <= count - (ADDR_W+1)'(1);
            // Loser of a contended cycle wins the next contention.
            if (pushOk && popOk)
                prio <= ~prio;
            pop_data_valid <= grant.pop;
        end
    end

`ifdef SRAM_FIFO_CTRL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_valid && full)
                overflow <= 1'b1;
            if (pop_req && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed, table-driven bench for sram_fifo_ctrl with a behavioural SRAM model.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_valid, pop_req;
    logic [7:0] push_data;
    logic       push_ready, pop_ready, pop_data_valid;
    logic [7:0] pop_data;
    logic       full, empty;
    logic [3:0] count;
    logic       sram_read, sram_write;
    logic [2:0] sram_addr;
    logic [7:0] sram_wdata, sram_rdata;
`ifdef SRAM_FIFO_CTRL_ERR_EN
    logic       overflow, underflow;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_req(pop_req), .pop_ready(pop_ready),
        .pop_data_valid(pop_data_valid), .pop_data(pop_data),
        .full(full), .empty(empty), .count(count),
        .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef SRAM_FIFO_CTRL_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // SRAM model: synchronous write, registered read data
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (sram_write) mem[sram_addr] <= sram_wdata;
        if (sram_read)  sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic       pushRdy, popRdy, wr, rd;
        logic [2:0] addr;
        logic [3:0] cnt;
        logic       emp, ful, pdv;
        logic [7:0] pdata;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic pv, input logic [7:0] pd, input logic pr,
                          input logic pushRdy, input logic popRdy, input logic wr, input logic rd,
                          input logic [2:0] addr, input logic [3:0] cnt,
                          input logic emp, input logic ful, input logic pdv, input logic [7:0] pdata);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pr = pr;
        v.pushRdy = pushRdy; v.popRdy = popRdy; v.wr = wr; v.rd = rd;
        v.addr = addr; v.cnt = cnt; v.emp = emp; v.ful = ful; v.pdv = pdv; v.pdata = pdata;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] sb[$];
    logic [7:0] expWord;
    logic [2:0] wrExp, rdExp;

    initial begin
        // idle, fill, push-when-full
        addVec(0, 8'h00, 0, 0,0,0,0, 3'd0, 4'd0, 1,0, 0, 8'h00);
        for (int i = 0; i < 8; i++)
            addVec(1, 8'((i+1)*17), 0, 1,0,1,0, 3'(i), 4'(i), i == 0, 0, 0, 8'h00);
        addVec(1, 8'h99, 0, 0,0,0,0, 3'd0, 4'd8, 0,1, 0, 8'h00);
        // drain with pop_req held; data lags grant by one cycle
        for (int i = 0; i < 8; i++)
            addVec(0, 8'h00, 1, 0,1,0,1, 3'(i), 4'(8-i), 0, i == 0, i > 0, 8'(i*17));
        addVec(0, 8'h00, 1, 0,0,0,0, 3'd0, 4'd0, 1,0, 1, 8'h88);
        addVec(0, 8'h00, 0, 0,0,0,0, 3'd0, 4'd0, 1,0, 0, 8'h00);
        // reach count=3, then contend for 4 cycles
        for (int i = 0; i < 3; i++)
            addVec(1, 8'(8'hA1 + i), 0, 1,0,1,0, 3'(i), 4'(i), i == 0, 0, 0, 8'h00);
        addVec(1, 8'hB1, 1, 1,0,1,0, 3'd3, 4'd3, 0,0, 0, 8'h00);
        addVec(1, 8'hB2, 1, 0,1,0,1, 3'd0, 4'd4, 0,0, 0, 8'h00);
        addVec(1, 8'hB2, 1, 1,0,1,0, 3'd4, 4'd3, 0,0, 1, 8'hA1);
        addVec(1, 8'hB3, 1, 0,1,0,1, 3'd1, 4'd4, 0,0, 0, 8'h00);
        addVec(0, 8'h00, 0, 0,0,0,0, 3'd2, 4'd3, 0,0, 1, 8'hA2);

        // reset with both requests asserted: grants and strobes must stay low
        rst = 1'b1; push_valid = 1'b1; pop_req = 1'b1; push_data = 8'h5A;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.push_ready", push_ready, 0);
        chk("rst.pop_ready", pop_ready, 0);
        chk("rst.strobes", {sram_read, sram_write}, 0);
        chk("rst.pdv", pop_data_valid, 0);
        chk("rst.count", count, 0);
        chk("rst.flags", {empty, full}, 2'b10);
`ifdef SRAM_FIFO_CTRL_ERR_EN
        chk("rst.err", {overflow, underflow}, 0);
`endif
        @(negedge clk);
        rst = 1'b0; push_valid = 1'b0; pop_req = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            push_valid = vecs[k].pv; push_data = vecs[k].pd; pop_req = vecs[k].pr;
            #1;
            chk($sformatf("v%0d.push_ready", k), push_ready, vecs[k].pushRdy);
            chk($sformatf("v%0d.pop_ready", k), pop_ready, vecs[k].popRdy);
            chk($sformatf("v%0d.sram_write", k), sram_write, vecs[k].wr);
            chk($sformatf("v%0d.sram_read", k), sram_read, vecs[k].rd);
            chk($sformatf("v%0d.sram_addr", k), sram_addr, vecs[k].addr);
            chk($sformatf("v%0d.count", k), count, vecs[k].cnt);
            chk($sformatf("v%0d.empty", k), empty, vecs[k].emp);
            chk($sformatf("v%0d.full", k), full, vecs[k].ful);
            chk($sformatf("v%0d.pdv", k), pop_data_valid, vecs[k].pdv);
            if (vecs[k].pdv)
                chk($sformatf("v%0d.pop_data", k), pop_data, vecs[k].pdata);
            if (vecs[k].wr)
                chk($sformatf("v%0d.sram_wdata", k), sram_wdata, vecs[k].pd);
        end
`ifdef SRAM_FIFO_CTRL_ERR_EN
        chk("err.overflow", overflow, 1);
        chk("err.underflow", underflow, 1);
`endif

        // wrap: 12 pushes interleaved with pops, pointers pass 7->0
        sb = '{8'hA3, 8'hB1, 8'hB2};
        wrExp = 3'd5; rdExp = 3'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            push_valid = 1'b1; push_data = 8'(8'hC0 + i); pop_req = 1'b0;
            #1;
            if (i > 0) begin
                chk($sformatf("wrap%0d.pdv", i), pop_data_valid, 1);
                chk($sformatf("wrap%0d.pop_data", i), pop_data, expWord);
            end
            chk($sformatf("wrap%0d.push", i), {push_ready, sram_write}, 2'b11);
            chk($sformatf("wrap%0d.waddr", i), sram_addr, wrExp);
            sb.push_back(push_data);
            wrExp = wrExp + 3'd1;
            @(negedge clk);
            push_valid = 1'b0; pop_req = 1'b1;
            #1;
            chk($sformatf("wrap%0d.pop", i), {pop_ready, sram_read}, 2'b11);
            chk($sformatf("wrap%0d.raddr", i), sram_addr, rdExp);
            expWord = sb.pop_front();
            rdExp = rdExp + 3'd1;
        end
        @(negedge clk);
        pop_req = 1'b1;
        #1;
        chk("wrap.last_pdv", pop_data_valid, 1);
        chk("wrap.last_data", pop_data, expWord);
        chk("wrap.count", count, 4'(sb.size()));

        // reset right after a pop grant drops the pending read
        @(negedge clk);
        #1;
        chk("rstpop.pdv_before", pop_data_valid, 1);
        rst = 1'b1;
        #1;
        chk("rstpop.pdv", pop_data_valid, 0);
        chk("rstpop.pop_ready", pop_ready, 0);
        chk("rstpop.sram_read", sram_read, 0);
        @(negedge clk);
        rst = 1'b0; pop_req = 1'b0;
        #1;
        chk("rstpop.count", count, 0);
        chk("rstpop.empty", empty, 1);
        chk("rstpop.raddr", sram_addr, 0);
        chk("rstpop.pdv_after", pop_data_valid, 0);
        @(negedge clk);
        push_valid = 1'b1; push_data = 8'h3C;
        #1;
        chk("rstpop.waddr", sram_addr, 0);
        chk("rstpop.push_ready", push_ready, 1);
`ifdef SRAM_FIFO_CTRL_ERR_EN
        chk("rstpop.err", {overflow, underflow}, 0);
`endif
        @(negedge clk);
        push_valid = 1'b0;
        #1;
        chk("rstpop.count1", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Controller that turns a single-port synchronous SRAM (read/write strobes, shared address, 1-cycle read latency) into a checked FIFO with full/empty tracking. It arbitrates the single SRAM port between a push requester and a pop requester: one SRAM operation per cycle, with alternating priority on contention. It sits between producer/consumer logic and the existing SRAM instance and owns all pointer and address generation.

Parameters:
WIDTH, 8, data word width in bits
ADDR_W, 3, SRAM address width; FIFO capacity = 2**ADDR_W entries

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
push_valid  in  1  producer has a word to write
push_data  in  WIDTH  word to write
push_ready  out  1  push accepted this cycle (comb.)
pop_req  in  1  consumer requests a word
pop_ready  out  1  pop accepted this cycle (comb.)
pop_data_valid  out  1  registered; pop_data valid this cycle
pop_data  out  WIDTH  = sram_rdata (pass-through)
full  out  1  count == 2**ADDR_W
empty  out  1  count == 0
count  out  ADDR_W+1  current occupancy
sram_read  out  1  SRAM read strobe
sram_write  out  1  SRAM write strobe
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  WIDTH  = push_data
sram_rdata  in  WIDTH  SRAM data out, valid the cycle after sram_read

Behaviour:
- Registered state: wr_ptr, rd_ptr (ADDR_W bits), count (ADDR_W+1), prio (1 bit), pop_data_valid.
- Reset: wr_ptr=rd_ptr=0, count=0, prio=0, pop_data_valid=0 -> empty=1, full=0. While rst is high, push_ready, pop_ready, sram_read and sram_write are forced to 0.
- Eligibility: push_ok = push_valid && !full; pop_ok = pop_req && !empty.
- Arbitration: if only one is eligible, it is granted. If both are, grant push when prio=0 and pop when prio=1. prio toggles only on a contended cycle, so the loser wins the next contention.
- Push grant: push_ready=1, sram_write=1, sram_addr=wr_ptr, sram_wdata=push_data. At the edge, wr_ptr+=1 (mod 2**ADDR_W).
- Pop grant: pop_ready=1, sram_read=1, sram_addr=rd_ptr. At the edge, rd_ptr+=1 (mod 2**ADDR_W) and pop_data_valid<=1. The next cycle presents pop_data, so latency is exactly 1 cycle from grant.
- No grant: strobes=0, sram_addr=rd_ptr, pop_data_valid<=0.
- sram_read and sram_write are never both 1.
- count: +1 on a push grant, -1 on a pop grant. The two never occur in the same cycle.
- Full: a push is held off (push_ready=0) with no SRAM write, and data is not overwritten. Pops proceed.
- Empty: a pop is held off with no SRAM read, and stale data is never returned. Pushes proceed.
- Pointer wrap is silent. full/empty derive from count, so equal pointers are unambiguous.
- Reset mid-operation: an in-flight read (pop_data_valid pending) is discarded, and pop_data_valid=0 immediately on rst assertion.
- Back-to-back pops are supported: one word per cycle, with pop_data_valid held high continuously.

Optional Feature:
Macro SRAM_FIFO_CTRL_ERR_EN.
- Defined: adds outputs overflow and underflow (1 bit each, sticky, cleared only by rst).
  - overflow sets on the first edge where push_valid && full.
  - underflow sets on the first edge where pop_req && empty.
- Not defined: these ports and their registers do not exist. Refused requests are simply not granted, with no other side effect.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, no strobes, pop_data_valid=0.
- Push 0x11..0x88 (8 words, ADDR_W=3) -> addresses 0..7 written in order, count=8, full=1. A 9th push 0x99 gets push_ready=0 and no sram_write (overflow=1 with ERR_EN).
- From full, pop_req held 8 cycles -> pop_data 0x11..0x88 in order, each 1 cycle after its grant, pop_data_valid high for 8 consecutive cycles. Then empty=1; a further pop is not granted (underflow=1 with ERR_EN).
- With count=3, push_valid and pop_req held together for 4 cycles -> grants alternate push, pop, push, pop starting with push (prio=0), and count ends at 3.
- Push 12 words interleaved with pops so pointers wrap past 7 -> data order preserved, addresses wrap 7->0.
- Assert rst the cycle after a pop grant -> pop_data_valid=0 during reset. After release: count=0, empty=1, pointers 0.
